// File: rtl/ldmac_pkg.sv
// rtl/ldmac_pkg.sv - shared defaults and FSM state encoding for the LDMAC feeder
//
// Contents:
//   DEF_WORD_W     default datapath word width (din/key/message)
//   DEF_KEY_WORDS  default key length in words
//   DEF_FIFO_DEPTH default message FIFO depth in words
//   state_t        feeder session state {IDLE, START, RUN}
package ldmac_pkg;

    localparam int DEF_WORD_W     = 64;
    localparam int DEF_KEY_WORDS  = 2;
    localparam int DEF_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/ldmac_msg_fifo.sv
// rtl/ldmac_msg_fifo.sv - synchronous message-word FIFO with show-ahead read data
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset; flushes the FIFO
//   push       write push_data (taken when not full, or when full with a pop)
//   push_data  word to store
//   pop        consume the head word (ignored when empty)
//   rdata      head word, valid in the same cycle as pop
//   full       DEPTH words stored
//   empty      no words stored
module ldmac_msg_fifo #(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot this cycle, so a full FIFO can still take a word.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/ldmac_feeder.sv
// rtl/ldmac_feeder.sv - LDMAC upstream stage: key store, message FIFO, session FSM
//
// Optional feature macro: LDMAC_FEED_UNDERFLOW_EN (sticky underflow flag; tied 0 when undefined)
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   key_we/idx/data     key word write, accepted in IDLE only
//   cmd_valid/rekey     session start request; cmd_ready = accepted this cycle
//   msg_valid/data      message word stream into the FIFO; msg_ready = FIFO can take it
//   load_k/load_m       core requests for next key/message word (served in RUN only)
//   done                core session complete (honoured in RUN only)
//   load_s1/load_s2     one-cycle start strobes (rekey / message-only session)
//   din                 registered word to the core, 1-cycle request latency
//   busy                session in progress
//   underflow           sticky message-underflow flag
module ldmac_feeder
    import ldmac_pkg::*;
#(
    parameter int WORD_W     = ldmac_pkg::DEF_WORD_W,
    parameter int KEY_WORDS  = ldmac_pkg::DEF_KEY_WORDS,
    parameter int FIFO_DEPTH = ldmac_pkg::DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_we,
    input  logic [$clog2(KEY_WORDS)-1:0] key_idx,
    input  logic [WORD_W-1:0]            key_data,
    input  logic                         cmd_valid,
    input  logic                         cmd_rekey,
    output logic                         cmd_ready,
    input  logic                         msg_valid,
    input  logic [WORD_W-1:0]            msg_data,
    output logic                         msg_ready,
    input  logic                         load_k,
    input  logic                         load_m,
    input  logic                         done,
    output logic                         load_s1,
    output logic                         load_s2,
    output logic [WORD_W-1:0]            din,
    output logic                         busy,
    output logic                         underflow
);

    localparam int KIW = $clog2(KEY_WORDS);

    state_t            state;
    logic [WORD_W-1:0] key [KEY_WORDS];
    logic [KIW-1:0]    kptr;

    logic              cmd_accept;
    logic              fifo_pop;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_rdata;

    assign cmd_accept = (state == IDLE) && cmd_valid;
    // Gated with rst so every output reads 0 while reset is held.
    assign cmd_ready  = rst && cmd_accept;
    assign busy       = (state != IDLE);

    // A simultaneous load_k wins the cycle, so the FIFO is left untouched.
    assign fifo_pop   = (state == RUN) && load_m && !load_k && !fifo_empty;
    assign msg_ready  = rst && (!fifo_full || fifo_pop);
    assign fifo_push  = msg_valid && msg_ready;

    ldmac_msg_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (msg_data),
        .pop       (fifo_pop),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            load_s1 <= 1'b0;
            load_s2 <= 1'b0;
            din     <= '0;
            kptr    <= '0;
            for (int i = 0; i < KEY_WORDS; i++) key[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Write and accept in one cycle both land; the key is read only in RUN.
                    if (key_we) key[key_idx] <= key_data;
                    if (cmd_valid) begin
                        load_s1 <= cmd_rekey;
                        load_s2 <= !cmd_rekey;
                        state   <= START;
                    end
                end
                START: begin
                    load_s1 <= 1'b0;
                    load_s2 <= 1'b0;
                    state   <= RUN;
                end
                RUN: begin
                    if (load_k) begin
                        din  <= key[kptr];
                        kptr <= (kptr == KIW'(KEY_WORDS - 1)) ? '0 : kptr + 1'b1;
                    end else if (load_m) begin
                        din <= fifo_empty ? '0 : fifo_rdata;
                    end
                    // Placed last so the session-end rewind overrides any advance above.
                    if (done) begin
                        state <= IDLE;
                        kptr  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LDMAC_FEED_UNDERFLOW_EN
    logic uf_event;
    assign uf_event = (state == RUN) && load_m && (load_k || fifo_empty);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            underflow <= 1'b0;
        else if (cmd_accept)
            underflow <= 1'b0;
        else if (uf_event)
            underflow <= 1'b1;
    end
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ldmac_feeder.sv
// tb/tb_ldmac_feeder.sv - self-checking bench for ldmac_feeder
module tb_ldmac_feeder;

    localparam logic [63:0] KA   = 64'hA5A5_0000_1111_2222;
    localparam logic [63:0] KB   = 64'h5A5A_3333_4444_5555;
    localparam logic [63:0] KX   = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] M0   = 64'h0000_0000_0000_00C0;
    localparam logic [63:0] M1   = 64'h0000_0000_0000_00C1;
    localparam logic [63:0] M2   = 64'h0000_0000_0000_00C2;
    localparam logic [63:0] M3   = 64'h0000_0000_0000_00C3;
`ifdef LDMAC_FEED_UNDERFLOW_EN
    localparam logic UF = 1'b1;
`else
    localparam logic UF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        key_we;
    logic [0:0]  key_idx;
    logic [63:0] key_data;
    logic        cmd_valid, cmd_rekey, cmd_ready;
    logic        msg_valid, msg_ready;
    logic [63:0] msg_data;
    logic        load_k, load_m, done;
    logic        load_s1, load_s2, busy, underflow;
    logic [63:0] din;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ldmac_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .key_we    (key_we),
        .key_idx   (key_idx),
        .key_data  (key_data),
        .cmd_valid (cmd_valid),
        .cmd_rekey (cmd_rekey),
        .cmd_ready (cmd_ready),
        .msg_valid (msg_valid),
        .msg_data  (msg_data),
        .msg_ready (msg_ready),
        .load_k    (load_k),
        .load_m    (load_m),
        .done      (done),
        .load_s1   (load_s1),
        .load_s2   (load_s2),
        .din       (din),
        .busy      (busy),
        .underflow (underflow)
    );

    typedef struct {
        logic        kwe;
        logic        kidx;
        logic [63:0] kd;
        logic        cv, cr, mv;
        logic [63:0] md;
        logic        lk, lm, dn;
        logic        x_cmd_ready, x_msg_ready, x_busy, x_s1, x_s2;
        logic [63:0] x_din;
        logic        x_uf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic kwe, input logic kidx, input logic [63:0] kd,
                               input logic cv, input logic cr, input logic mv, input logic [63:0] md,
                               input logic lk, input logic lm, input logic dn,
                               input logic xcr, input logic xmr, input logic xb, input logic xs1,
                               input logic xs2, input logic [63:0] xdin, input logic xuf);
        vec_t r;
        r.kwe = kwe; r.kidx = kidx; r.kd = kd;
        r.cv = cv; r.cr = cr; r.mv = mv; r.md = md;
        r.lk = lk; r.lm = lm; r.dn = dn;
        r.x_cmd_ready = xcr; r.x_msg_ready = xmr; r.x_busy = xb;
        r.x_s1 = xs1; r.x_s2 = xs2; r.x_din = xdin; r.x_uf = xuf;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        key_we = 0; key_idx = 0; key_data = '0;
        cmd_valid = 0; cmd_rekey = 0;
        msg_valid = 0; msg_data = '0;
        load_k = 0; load_m = 0; done = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        idle_inputs();
        rst = 0;
        cmd_valid = 1;
        repeat (2) @(posedge clk);
        #2;
        check("reset busy", busy, 0);
        check("reset din", din, 0);
        check("reset load_s1", load_s1, 0);
        check("reset load_s2", load_s2, 0);
        check("reset cmd_ready", cmd_ready, 0);
        check("reset msg_ready", msg_ready, 0);
        check("reset underflow", underflow, 0);
        cmd_valid = 0;
        rst = 1;
        tick();

        // ---------------- table-driven sessions ----------------
        //             kwe k kd   cv cr mv md   lk lm dn  cr mr b  s1 s2 din uf
        vecs.push_back(v(1, 0, KA, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0,  0));
        vecs.push_back(v(1, 1, KB, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0,  0));
        vecs.push_back(v(0, 0, 0,  1, 1, 0, 0,  0, 0, 0,  1, 1, 1, 1, 0, 0,  0));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 1, 1, 0, 0, 0,  0));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 1, 1, 0, 0, KA, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 1, 1, 0, 0, KB, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 1, 1, 0, 0, KA, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  0, 0, 1,  0, 1, 0, 0, 0, KA, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 1, M0, 1, 0, 1,  0, 1, 0, 0, 0, KA, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 1, M1, 0, 0, 0,  0, 1, 0, 0, 0, KA, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 1, M2, 0, 0, 0,  0, 1, 0, 0, 0, KA, 0));
        vecs.push_back(v(0, 0, 0,  1, 0, 0, 0,  0, 0, 0,  1, 1, 1, 0, 1, KA, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 1, 1, 0, 0, KA, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  0, 1, 0,  0, 1, 1, 0, 0, M0, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  0, 1, 0,  0, 1, 1, 0, 0, M1, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  0, 1, 0,  0, 1, 1, 0, 0, M2, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  0, 1, 0,  0, 1, 1, 0, 0, 0,  UF));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 1, 1, 0, 0, 0,  UF));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 1, 1, 0, 0, KA, UF));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  0, 0, 1,  0, 1, 0, 0, 0, KA, UF));
        vecs.push_back(v(0, 0, 0,  1, 1, 0, 0,  0, 0, 0,  1, 1, 1, 1, 0, KA, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 1, M3, 1, 0, 0,  0, 1, 1, 0, 0, KA, 0));
        vecs.push_back(v(1, 0, KX, 0, 0, 0, 0,  1, 0, 0,  0, 1, 1, 0, 0, KA, 0));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  1, 1, 0,  0, 1, 1, 0, 0, KB, UF));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  0, 1, 0,  0, 1, 1, 0, 0, M3, UF));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 1, 1, 0, 0, KA, UF));
        vecs.push_back(v(0, 0, 0,  0, 0, 0, 0,  0, 0, 1,  0, 1, 0, 0, 0, KA, UF));

        foreach (vecs[i]) begin
            key_we = vecs[i].kwe; key_idx = vecs[i].kidx; key_data = vecs[i].kd;
            cmd_valid = vecs[i].cv; cmd_rekey = vecs[i].cr;
            msg_valid = vecs[i].mv; msg_data = vecs[i].md;
            load_k = vecs[i].lk; load_m = vecs[i].lm; done = vecs[i].dn;
            #1;
            check($sformatf("row%0d cmd_ready", i), cmd_ready, vecs[i].x_cmd_ready);
            check($sformatf("row%0d msg_ready", i), msg_ready, vecs[i].x_msg_ready);
            @(posedge clk);
            #2;
            check($sformatf("row%0d busy", i), busy, vecs[i].x_busy);
            check($sformatf("row%0d load_s1", i), load_s1, vecs[i].x_s1);
            check($sformatf("row%0d load_s2", i), load_s2, vecs[i].x_s2);
            check($sformatf("row%0d din", i), din, vecs[i].x_din);
            check($sformatf("row%0d underflow", i), underflow, vecs[i].x_uf);
        end
        idle_inputs();

        // ---------------- full FIFO, push+pop while full ----------------
        for (int i = 0; i < 16; i++) begin
            msg_valid = 1; msg_data = 64'h1000 + 64'(i);
            #1;
            check($sformatf("fill%0d msg_ready", i), msg_ready, 1);
            tick();
        end
        msg_valid = 0;
        #1;
        check("full msg_ready", msg_ready, 0);
        msg_valid = 1; msg_data = 64'h0BAD;   // dropped: FIFO full, no pop
        tick();
        msg_valid = 0;
        cmd_valid = 1; cmd_rekey = 0;
        tick();
        cmd_valid = 0;
        check("full load_s2", load_s2, 1);
        tick();
        load_m = 1; msg_valid = 1; msg_data = 64'hBEEF;
        #1;
        check("full pushpop msg_ready", msg_ready, 1);
        tick();
        check("full pushpop din", din, 64'h1000);
        load_m = 0; msg_valid = 0;
        #1;
        check("still full msg_ready", msg_ready, 0);
        for (int i = 1; i < 16; i++) begin
            load_m = 1;
            tick();
            check($sformatf("drain%0d din", i), din, 64'h1000 + 64'(i));
        end
        tick();
        check("drain last din", din, 64'hBEEF);
        tick();
        check("drain empty din", din, 0);
        check("drain empty underflow", underflow, UF);
        load_m = 0; done = 1;
        tick();
        done = 0;
        check("drain done busy", busy, 0);

        // ---------------- reset mid-RUN ----------------
        for (int i = 0; i < 3; i++) begin
            msg_valid = 1; msg_data = 64'h2000 + 64'(i);
            tick();
        end
        msg_valid = 0;
        cmd_valid = 1; cmd_rekey = 1;
        tick();
        cmd_valid = 0;
        tick();
        load_k = 1;
        tick();
        load_k = 0;
        check("pre-reset din", din, KA);
        check("pre-reset busy", busy, 1);
        rst = 0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst din", din, 0);
        check("midrst load_s1", load_s1, 0);
        check("midrst load_s2", load_s2, 0);
        check("midrst underflow", underflow, 0);
        @(negedge clk);
        rst = 1;
        tick();
        msg_valid = 1; msg_data = 64'h3000;
        tick();
        msg_valid = 0;
        cmd_valid = 1; cmd_rekey = 0;
        tick();
        cmd_valid = 0;
        tick();
        load_m = 1;
        tick();
        check("post-reset fifo head", din, 64'h3000);
        load_m = 0; load_k = 1;
        tick();
        check("post-reset key cleared", din, 0);
        load_k = 0; load_m = 1;
        tick();
        check("post-reset fifo empty din", din, 0);
        check("post-reset fifo empty underflow", underflow, UF);
        load_m = 0; done = 1;
        tick();
        done = 0;

        // ---------------- held cmd_valid, done in START/RUN ----------------
        cmd_valid = 1; cmd_rekey = 0;
        #1;
        check("held accept cmd_ready", cmd_ready, 1);
        tick();
        check("held load_s2", load_s2, 1);
        done = 1;   // ignored in START
        #1;
        check("held START cmd_ready", cmd_ready, 0);
        tick();
        check("done in START busy", busy, 1);
        done = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("held RUN%0d cmd_ready", i), cmd_ready, 0);
            tick();
        end
        done = 1;
        #1;
        check("held done cmd_ready", cmd_ready, 0);
        tick();
        done = 0;
        check("done busy", busy, 0);
        #1;
        check("held IDLE cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 0;
        check("held reaccept busy", busy, 1);
        check("held reaccept load_s2", load_s2, 1);
        tick();
        done = 1;
        tick();
        done = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
